// File: rtl/lifo_arb_pkg.sv
// Shared types for the LIFO arbiter: op encoding and the registered response record.
package lifo_arb_pkg;

   localparam int ARB_DATA_W  = 4;
   localparam int ARB_NUM_REQ = 2;
   localparam int ARB_ID_W    = $clog2(ARB_NUM_REQ);

   localparam logic OP_PUSH = 1'b1;
   localparam logic OP_POP  = 1'b0;

   typedef struct packed {
      logic [ARB_ID_W-1:0]   id;
      logic                  push;
      logic [ARB_DATA_W-1:0] data;
      logic                  err;
   } rsp_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: searches from last_grant+1, holds last_grant until a transfer.
module rr_arbiter #(
   parameter int NUM_REQ = 2,
   parameter int ID_W    = $clog2(NUM_REQ)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NUM_REQ-1:0] req,
   input  logic               advance,
   output logic [NUM_REQ-1:0] grant,
   output logic [ID_W-1:0]    grant_idx
);

   logic [ID_W-1:0] last_grant_q, last_grant_d;
   logic            found;
   int              cand;

   always_comb begin
      grant     = '0;
      grant_idx = '0;
      found     = 1'b0;
      cand      = 0;
      for (int off = 1; off <= NUM_REQ; off++) begin
         cand = (int'(last_grant_q) + off) % NUM_REQ;
         if (!found && req[cand]) begin
            grant[cand] = 1'b1;
            grant_idx   = ID_W'(cand);
            found       = 1'b1;
         end
      end
   end

   always_comb begin
      last_grant_d = last_grant_q;
      if (advance) last_grant_d = grant_idx;
   end

   // Reset to the highest index so requester 0 wins first.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) last_grant_q <= ID_W'(NUM_REQ - 1);
      else        last_grant_q <= last_grant_d;
   end

endmodule

// File: rtl/lifo_arbiter.sv
// Single LIFO stack shared by NUM_REQ clients; one op per cycle with a tagged registered response.
module lifo_arbiter
   import lifo_arb_pkg::*;
#(
   parameter int DATA_W  = ARB_DATA_W,
   parameter int DEPTH   = 16,
   parameter int NUM_REQ = ARB_NUM_REQ,
   parameter int ID_W    = $clog2(NUM_REQ),
   parameter int CNT_W   = $clog2(DEPTH + 1)
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [NUM_REQ-1:0]          req_valid,
   input  logic [NUM_REQ-1:0]          req_push,
   input  logic [NUM_REQ*DATA_W-1:0]   req_data,
   output logic [NUM_REQ-1:0]          req_ready,
   output logic                        rsp_valid,
   output logic [ID_W-1:0]             rsp_id,
   output logic                        rsp_push,
   output logic [DATA_W-1:0]           rsp_data,
   output logic                        rsp_err,
   output logic [CNT_W-1:0]            count,
   output logic                        full,
   output logic                        empty
);

   localparam int IDX_W = $clog2(DEPTH);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [CNT_W-1:0]  count_q, count_d;
   logic              rsp_valid_q, rsp_valid_d;
   rsp_t              rsp_q, rsp_d;

   logic [NUM_REQ-1:0] gnt;
   logic [ID_W-1:0]    gnt_idx;
   logic               xfer;
   logic               op_push;
   logic [DATA_W-1:0]  op_data;
   logic               full_q, empty_q;
   logic               wr_en;
   logic [IDX_W-1:0]   wr_idx, rd_idx;

   rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_arb (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (req_valid),
      .advance   (xfer),
      .grant     (gnt),
      .grant_idx (gnt_idx)
   );

   assign xfer    = |(req_valid & gnt);
   assign op_push = req_push[gnt_idx];
   assign op_data = req_data[int'(gnt_idx)*DATA_W +: DATA_W];
   assign full_q  = (count_q == CNT_W'(DEPTH));
   assign empty_q = (count_q == '0);
   // At DEPTH the truncated write index aliases entry 0, but wr_en is never set when full.
   assign wr_idx  = IDX_W'(count_q);
   assign rd_idx  = IDX_W'(count_q - 1'b1);

   always_comb begin
      count_d     = count_q;
      rsp_valid_d = xfer;
      rsp_d       = '0;
      wr_en       = 1'b0;
      if (xfer) begin
         rsp_d.id   = gnt_idx;
         rsp_d.push = op_push;
         if (op_push == OP_PUSH) begin
            if (full_q) begin
               rsp_d.err = 1'b1;
            end else begin
               wr_en   = 1'b1;
               count_d = count_q + 1'b1;
            end
         end else begin
            if (empty_q) begin
               rsp_d.err = 1'b1;
            end else begin
               rsp_d.data = mem_q[rd_idx];
               count_d    = count_q - 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q     <= '0;
         rsp_valid_q <= 1'b0;
         rsp_q       <= '0;
      end else begin
         count_q     <= count_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_q       <= rsp_d;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) mem_q[wr_idx] <= op_data;
   end

   assign req_ready = gnt;
   assign rsp_valid = rsp_valid_q;
   assign rsp_id    = rsp_q.id;
   assign rsp_push  = rsp_q.push;
   assign rsp_data  = rsp_q.data;
   assign rsp_err   = rsp_q.err;
   assign count     = count_q;
   assign full      = full_q;
   assign empty     = empty_q;

endmodule

// File: tb/tb_lifo_arbiter.sv
// Bench for lifo_arbiter: directed boundary steps plus random traffic against a queue-based stack model.
module tb_lifo_arbiter;

   localparam int DW    = 4;
   localparam int DEPTH = 16;
   localparam int NR    = 2;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic [NR-1:0]    req_valid = '0;
   logic [NR-1:0]    req_push = '0;
   logic [NR*DW-1:0] req_data = '0;
   logic [NR-1:0]    req_ready;
   logic             rsp_valid;
   logic [0:0]       rsp_id;
   logic             rsp_push;
   logic [DW-1:0]    rsp_data;
   logic             rsp_err;
   logic [4:0]       count;
   logic             full;
   logic             empty;

   lifo_arbiter dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_push  (req_push),
      .req_data  (req_data),
      .req_ready (req_ready),
      .rsp_valid (rsp_valid),
      .rsp_id    (rsp_id),
      .rsp_push  (rsp_push),
      .rsp_data  (rsp_data),
      .rsp_err   (rsp_err),
      .count     (count),
      .full      (full),
      .empty     (empty)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Reference model: a plain queue as the stack and the last granted index.
   int         lg = NR - 1;
   logic [3:0] stk[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      lg = NR - 1;
      stk.delete();
   endtask

   task automatic model_arb(input logic [NR-1:0] v, output logic [NR-1:0] g, output int idx);
      g   = '0;
      idx = -1;
      for (int off = 1; off <= NR; off++) begin
         int c;
         c = (lg + off) % NR;
         if (idx < 0 && v[c]) begin
            idx  = c;
            g[c] = 1'b1;
         end
      end
   endtask

   // Called at posedge+1; drives one cycle of requests and checks grant, response and occupancy.
   task automatic do_cycle(input logic [NR-1:0] v, input logic [NR-1:0] p,
                           input logic [3:0] d0, input logic [3:0] d1,
                           output logic [NR-1:0] obs_g, output logic [3:0] exp_data);
      logic [NR-1:0] g;
      int            idx;
      logic          e_valid, e_push, e_err;
      logic [3:0]    e_data, d;
      req_valid = v;
      req_push  = p;
      req_data  = {d1, d0};
      #2;
      model_arb(v, g, idx);
      obs_g = req_ready;
      chk("grant", req_ready, g);
      e_valid = (idx >= 0);
      e_push  = 1'b0;
      e_err   = 1'b0;
      e_data  = '0;
      if (e_valid) begin
         lg     = idx;
         e_push = p[idx];
         d      = (idx == 0) ? d0 : d1;
         if (e_push) begin
            if (stk.size() == DEPTH) e_err = 1'b1;
            else stk.push_back(d);
         end else begin
            if (stk.size() == 0) e_err = 1'b1;
            else e_data = stk.pop_back();
         end
      end
      exp_data = e_data;
      @(posedge clk);
      #1;
      chk("rsp_valid", rsp_valid, e_valid);
      if (e_valid) begin
         chk("rsp_id", rsp_id, idx);
         chk("rsp_push", rsp_push, e_push);
         chk("rsp_data", rsp_data, e_data);
         chk("rsp_err", rsp_err, e_err);
      end
      chk("count", count, stk.size());
      chk("full", full, stk.size() == DEPTH);
      chk("empty", empty, stk.size() == 0);
   endtask

   initial begin
      logic [NR-1:0] og;
      logic [3:0]    rd;
      logic [3:0]    last_val;

      // Reset
      repeat (3) @(posedge clk);
      #3 rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("rst_empty", empty, 1'b1);
      chk("rst_count", count, 0);
      chk("rst_full", full, 1'b0);
      chk("rst_rsp_valid", rsp_valid, 1'b0);
      #1;
      chk("rst_no_grant", req_ready, 2'b00);
      @(posedge clk);
      #1;

      // Round-robin fairness, both pushing continuously
      for (int i = 0; i < 4; i++) begin
         do_cycle(2'b11, 2'b11, 4'($urandom), 4'($urandom), og, rd);
         chk("rr_order", og, (i % 2 == 0) ? 2'b01 : 2'b10);
      end
      for (int i = 0; i < 4; i++) do_cycle(2'b01, 2'b00, 4'h0, 4'h0, og, rd);

      // Single-client LIFO order
      do_cycle(2'b01, 2'b01, 4'd3, 4'h0, og, rd);
      do_cycle(2'b01, 2'b01, 4'd7, 4'h0, og, rd);
      do_cycle(2'b01, 2'b01, 4'd9, 4'h0, og, rd);
      do_cycle(2'b01, 2'b00, 4'h0, 4'h0, og, rd);
      chk("lifo_pop1", rsp_data, 4'd9);
      do_cycle(2'b01, 2'b00, 4'h0, 4'h0, og, rd);
      chk("lifo_pop2", rsp_data, 4'd7);
      do_cycle(2'b01, 2'b00, 4'h0, 4'h0, og, rd);
      chk("lifo_pop3", rsp_data, 4'd3);
      chk("lifo_count0", count, 0);

      // Full boundary
      last_val = '0;
      for (int i = 0; i < DEPTH; i++) begin
         last_val = 4'($urandom);
         do_cycle(2'b10, 2'b10, 4'h0, last_val, og, rd);
      end
      chk("full_flag", full, 1'b1);
      chk("full_count", count, DEPTH);
      do_cycle(2'b10, 2'b10, 4'h0, 4'hF, og, rd);
      chk("push_full_err", rsp_err, 1'b1);
      chk("push_full_count", count, DEPTH);
      do_cycle(2'b10, 2'b00, 4'h0, 4'h0, og, rd);
      chk("pop_after_full", rsp_data, last_val);

      // Empty boundary
      while (stk.size() > 0) do_cycle(2'b01, 2'b00, 4'h0, 4'h0, og, rd);
      do_cycle(2'b01, 2'b00, 4'h0, 4'h0, og, rd);
      chk("pop_empty_err", rsp_err, 1'b1);
      chk("pop_empty_data", rsp_data, 4'h0);
      chk("pop_empty_count", count, 0);
      do_cycle(2'b01, 2'b01, 4'd5, 4'h0, og, rd);
      do_cycle(2'b01, 2'b00, 4'h0, 4'h0, og, rd);
      chk("push_pop_b2b", rsp_data, 4'd5);

      // Random traffic
      for (int i = 0; i < 400; i++) begin
         do_cycle(2'($urandom), 2'($urandom), 4'($urandom), 4'($urandom), og, rd);
      end

      // Reset mid-traffic
      do_cycle(2'b01, 2'b01, 4'hA, 4'h0, og, rd);
      do_cycle(2'b01, 2'b01, 4'hB, 4'h0, og, rd);
      chk("pre_rst_valid", rsp_valid, 1'b1);
      req_valid = 2'b01;
      req_push  = 2'b01;
      req_data  = {4'h0, 4'hC};
      #1;
      chk("pre_rst_grant", req_ready, 2'b01);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", rsp_valid, 1'b0);
      chk("mid_rst_count", count, 0);
      chk("mid_rst_empty", empty, 1'b1);
      model_reset();
      req_valid = '0;
      @(posedge clk);
      #2 rst_n = 1'b1;
      @(posedge clk);
      #1;
      do_cycle(2'b01, 2'b00, 4'h0, 4'h0, og, rd);
      chk("post_rst_pop_err", rsp_err, 1'b1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
